// File: rtl/muxf7_rr_sched.sv
// Round-robin scheduler for a shared 2:1 wide mux with valid/ready inputs,
// per-grant burst limit and one registered output stage (O with local copy LO).
module muxf7_rr_sched #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             CE,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] D0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] D1,
  output logic             ACK1,
  output logic             S,
  output logic [WIDTH-1:0] O,
  output logic [WIDTH-1:0] LO,
  output logic             OV,
  input  logic             ORDY,
  output logic             BUSY
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_q, last_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               ov_q, ov_d;
  logic               s_q, s_d;
  logic               busy_q, busy_d;

  logic               ack0_c, ack1_c;
  logic               xfer0_c, xfer1_c;
  logic               drain_c;

  // Handshake decode; ready only toward the granted side and only when O can accept.
  assign ack0_c  = CE & (state_q == GNT0) & (~ov_q | ORDY);
  assign ack1_c  = CE & (state_q == GNT1) & (~ov_q | ORDY);
  assign xfer0_c = REQ0 & ack0_c;
  assign xfer1_c = REQ1 & ack1_c;
  assign drain_c = CE & ov_q & ORDY;

  // Next-state, burst counter and output stage update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    o_d     = o_q;
    lo_d    = lo_q;
    ov_d    = ov_q;

    if (CE) begin
      if (xfer0_c) begin
        o_d  = D0;
        lo_d = D0;
        ov_d = 1'b1;
      end else if (xfer1_c) begin
        o_d  = D1;
        lo_d = D1;
        ov_d = 1'b1;
      end else if (drain_c) begin
        ov_d = 1'b0;
      end

      unique case (state_q)
        IDLE: begin
          if (REQ0 && REQ1) begin
            state_d = last_q ? GNT0 : GNT1;
          end else if (REQ0) begin
            state_d = GNT0;
          end else if (REQ1) begin
            state_d = GNT1;
          end
        end
        GNT0: begin
          if ((xfer0_c && (cnt_q == CNT_LAST)) || !REQ0) begin
            last_d  = 1'b0;
            cnt_d   = '0;
            state_d = REQ1 ? GNT1 : (REQ0 ? GNT0 : IDLE);
          end else if (xfer0_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        GNT1: begin
          if ((xfer1_c && (cnt_q == CNT_LAST)) || !REQ1) begin
            last_d  = 1'b1;
            cnt_d   = '0;
            state_d = REQ0 ? GNT0 : (REQ1 ? GNT1 : IDLE);
          end else if (xfer1_c) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    s_d    = (state_d == GNT1);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; CE=0 holds everything because *_d defaults to *_q.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      o_q     <= '0;
      lo_q    <= '0;
      ov_q    <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      o_q     <= o_d;
      lo_q    <= lo_d;
      ov_q    <= ov_d;
      s_q     <= s_d;
      busy_q  <= busy_d;
    end
  end

  assign ACK0 = ack0_c;
  assign ACK1 = ack1_c;
  assign S    = s_q;
  assign BUSY = busy_q;
  assign O    = o_q;
  assign LO   = lo_q;
  assign OV   = ov_q;

endmodule

// File: tb/tb_muxf7_rr_sched.sv
// Directed bench for muxf7_rr_sched: reset, streaming, arbitration, stall,
// grant drop, clock-enable freeze and LAST-based tie-break.
module tb_muxf7_rr_sched;

  localparam int unsigned WIDTH = 8;

  logic             C = 1'b0;
  logic             CLR, CE, REQ0, REQ1, ORDY;
  logic [WIDTH-1:0] D0, D1;
  logic             ACK0, ACK1, S, OV, BUSY;
  logic [WIDTH-1:0] O, LO;

  int checks   = 0;
  int failures = 0;

  muxf7_rr_sched #(.WIDTH(WIDTH), .MAX_BURST(4)) dut (
    .C(C), .CLR(CLR), .CE(CE),
    .REQ0(REQ0), .D0(D0), .ACK0(ACK0),
    .REQ1(REQ1), .D1(D1), .ACK1(ACK1),
    .S(S), .O(O), .LO(LO), .OV(OV), .ORDY(ORDY), .BUSY(BUSY)
  );

  always #5 C = ~C;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge C);
    #1;
  endtask

  initial begin
    logic [7:0] exp_o;
    int side;

    CLR = 1'b1; CE = 1'b1; ORDY = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0; D0 = '0; D1 = '0;
    repeat (2) tick();
    check_eq("rst_o",    32'(O),    32'h0);
    check_eq("rst_lo",   32'(LO),   32'h0);
    check_eq("rst_ov",   32'(OV),   32'h0);
    check_eq("rst_s",    32'(S),    32'h0);
    check_eq("rst_busy", 32'(BUSY), 32'h0);
    check_eq("rst_ack0", 32'(ACK0), 32'h0);
    CLR = 1'b0;

    // Requester 0 alone: 8 beats back-to-back across a burst boundary
    REQ0 = 1'b1; D0 = 8'h10;
    #1;
    check_eq("idle_ack0", 32'(ACK0), 32'h0);
    tick();
    for (int i = 0; i < 8; i++) begin
      D0 = 8'(8'h10 + i);
      #1;
      check_eq("solo_ack0", 32'(ACK0), 32'h1);
      check_eq("solo_s",    32'(S),    32'h0);
      check_eq("solo_busy", 32'(BUSY), 32'h1);
      if (i > 0) begin
        check_eq("solo_o",  32'(O),  32'(8'h10 + i - 1));
        check_eq("solo_ov", 32'(OV), 32'h1);
      end
      tick();
    end
    check_eq("solo_o_last", 32'(O), 32'h17);
    REQ0 = 1'b0;
    tick();
    check_eq("solo_drain_ov", 32'(OV),   32'h0);
    check_eq("solo_idle",     32'(BUSY), 32'h0);

    // Both request, LAST=0 so requester 1 wins; CLR mid-burst
    REQ0 = 1'b1; REQ1 = 1'b1; D0 = 8'hA0; D1 = 8'hB0;
    #1;
    check_eq("idle_ack1", 32'(ACK1), 32'h0);
    tick();
    check_eq("g1_s",    32'(S),    32'h1);
    check_eq("g1_ack1", 32'(ACK1), 32'h1);
    check_eq("g1_ack0", 32'(ACK0), 32'h0);
    tick();
    D1 = 8'hB1;
    tick();
    check_eq("pre_clr_o", 32'(O),  32'hB1);
    check_eq("pre_clr_s", 32'(S),  32'h1);
    CLR = 1'b1;
    #1;
    check_eq("clr_o",    32'(O),    32'h0);
    check_eq("clr_lo",   32'(LO),   32'h0);
    check_eq("clr_ov",   32'(OV),   32'h0);
    check_eq("clr_s",    32'(S),    32'h0);
    check_eq("clr_busy", 32'(BUSY), 32'h0);
    check_eq("clr_ack1", 32'(ACK1), 32'h0);
    tick();
    CLR = 1'b0;

    // Both held after reset: alternate 4 beats of D0, 4 of D1
    #1;
    check_eq("post_clr_ack0", 32'(ACK0), 32'h0);
    tick();
    exp_o = 8'h00;
    for (int k = 0; k < 16; k++) begin
      D0 = 8'(8'h40 + k);
      D1 = 8'(8'h80 + k);
      side = (k / 4) % 2;
      #1;
      check_eq("alt_s",    32'(S),    32'(side));
      check_eq("alt_ack0", 32'(ACK0), 32'(side == 0));
      check_eq("alt_ack1", 32'(ACK1), 32'(side));
      if (k > 0) check_eq("alt_o", 32'(O), 32'(exp_o));
      check_eq("alt_lo", 32'(LO), 32'(O));
      exp_o = (side == 0) ? 8'(8'h40 + k) : 8'(8'h80 + k);
      tick();
    end
    check_eq("alt_o_last", 32'(O), 32'h8F);

    // Stall in GNT0 for 5 cycles, then drain+load; count must not advance
    REQ1 = 1'b0; ORDY = 1'b0; D0 = 8'hC0;
    for (int j = 0; j < 5; j++) begin
      #1;
      check_eq("stall_ack0", 32'(ACK0), 32'h0);
      check_eq("stall_o",    32'(O),    32'h8F);
      check_eq("stall_ov",   32'(OV),   32'h1);
      check_eq("stall_s",    32'(S),    32'h0);
      tick();
    end
    ORDY = 1'b1;
    #1;
    check_eq("unstall_ack0", 32'(ACK0), 32'h1);
    tick();
    check_eq("unstall_o",  32'(O),  32'hC0);
    check_eq("unstall_ov", 32'(OV), 32'h1);
    REQ1 = 1'b1; D1 = 8'hD0;
    for (int j = 1; j < 4; j++) begin
      D0 = 8'(8'hC0 + j);
      #1;
      check_eq("stall_burst_ack0", 32'(ACK0), 32'h1);
      check_eq("stall_burst_s",    32'(S),    32'h0);
      tick();
    end
    check_eq("stall_sw_s",    32'(S),    32'h1);
    check_eq("stall_sw_ack1", 32'(ACK1), 32'h1);
    check_eq("stall_sw_o",    32'(O),    32'hC3);

    // GNT1: two beats, then REQ1 drops with REQ0 waiting
    D1 = 8'hD0;
    tick();
    D1 = 8'hD1;
    tick();
    REQ1 = 1'b0;
    tick();
    check_eq("drop_s",    32'(S),    32'h0);
    check_eq("drop_ack0", 32'(ACK0), 32'h1);
    check_eq("drop_o",    32'(O),    32'hD1);
    REQ1 = 1'b1; D1 = 8'hF0;
    for (int j = 0; j < 4; j++) begin
      D0 = 8'(8'hE0 + j);
      #1;
      check_eq("drop_burst_s", 32'(S), 32'h0);
      tick();
    end
    check_eq("drop_sw_s", 32'(S), 32'h1);
    check_eq("drop_sw_o", 32'(O), 32'hE3);

    // CE low for 3 cycles mid-burst in GNT1
    tick();
    CE = 1'b0; D1 = 8'hF1;
    for (int j = 0; j < 3; j++) begin
      #1;
      check_eq("ce_ack0", 32'(ACK0), 32'h0);
      check_eq("ce_ack1", 32'(ACK1), 32'h0);
      check_eq("ce_o",    32'(O),    32'hF0);
      check_eq("ce_ov",   32'(OV),   32'h1);
      check_eq("ce_s",    32'(S),    32'h1);
      check_eq("ce_busy", 32'(BUSY), 32'h1);
      tick();
    end
    CE = 1'b1;
    for (int j = 1; j < 4; j++) begin
      D1 = 8'(8'hF0 + j);
      #1;
      check_eq("ce_res_ack1", 32'(ACK1), 32'h1);
      check_eq("ce_res_s",    32'(S),    32'h1);
      tick();
    end
    check_eq("ce_sw_s", 32'(S), 32'h0);
    check_eq("ce_sw_o", 32'(O), 32'hF3);

    // Requester 0 ends its grant; LAST=0 makes the next tie go to requester 1
    REQ0 = 1'b0; REQ1 = 1'b0;
    tick();
    check_eq("end_busy", 32'(BUSY), 32'h0);
    check_eq("end_ov",   32'(OV),   32'h0);
    REQ0 = 1'b1; REQ1 = 1'b1;
    tick();
    check_eq("tie_s",    32'(S),    32'h1);
    check_eq("tie_ack1", 32'(ACK1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
